// File: rtl/gf2_mul_raw_163_if.sv
// gf2_mul_raw_163_if: operand/product handshake bundle for the raw GF(2) multiplier
interface gf2_mul_raw_163_if;
    logic         in_valid;
    logic         in_ready;
    logic [162:0] a;
    logic [162:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [325:0] product;
    logic         busy;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, product, busy);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, product, busy);
endinterface

// File: rtl/gf2_mul_raw_163.sv
// gf2_mul_raw_163: digit-serial carry-less 163x163 multiplier producing the unreduced 326-bit product
module gf2_mul_raw_163 #(
    parameter int DIGIT = 8
) (
    input logic               clk,
    input logic               rst_n,
    gf2_mul_raw_163_if.slave  bus
);
    localparam int NDIG = (163 + DIGIT - 1) / DIGIT;
    localparam int BW   = NDIG * DIGIT;
    localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
    if (DIGIT < 1 || DIGIT > 163) begin : g_bad_digit
        $error("gf2_mul_raw_163: DIGIT must be in 1..163");
    end
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state, state_nxt;
    logic [162:0]    a_reg;
    logic [BW-1:0]   b_reg;
    logic [CW-1:0]   cnt;
    logic [325:0]    acc, acc_nxt, part, prod;
    logic [DIGIT-1:0] digit;
    logic            accept;
    assign accept        = bus.in_valid && state == IDLE;
    assign digit         = b_reg[cnt*DIGIT +: DIGIT];
    assign acc_nxt       = (acc << DIGIT) ^ part;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.product   = prod;
    // Carry-less partial product of A with the current B digit
    always_comb begin
        part = '0;
        for (int j = 0; j < DIGIT; j++)
            part = part ^ (digit[j] ? ({163'b0, a_reg} << j) : 326'b0);
    end
    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    // Next state: accept in IDLE, NDIG digit steps in RUN, hold in DONE until taken
    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = RUN;
        if (state == RUN && cnt == '0) state_nxt = DONE;
        if (state == DONE && bus.out_ready) state_nxt = IDLE;
    end
    // Operand capture, MSB-first digit accumulation and product write-back
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            acc   <= '0;
            prod  <= '0;
        end else if (accept) begin
            a_reg <= bus.a;
            b_reg <= BW'(bus.b);
            cnt   <= CW'(NDIG - 1);
            acc   <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) prod <= acc_nxt;
        end
endmodule

// File: tb/tb_gf2_mul_raw_163.sv
// tb_gf2_mul_raw_163: table-driven and sequence checks of the raw GF(2) multiplier
module tb_gf2_mul_raw_163;
    logic clk, rst_n;
    int   errors = 0;
    int   checks = 0;
    gf2_mul_raw_163_if m ();
    gf2_mul_raw_163_if i1 ();
    gf2_mul_raw_163_if i7 ();
    gf2_mul_raw_163_if i163 ();
    gf2_mul_raw_163 u_dut (.clk(clk), .rst_n(rst_n), .bus(m));
    gf2_mul_raw_163 #(.DIGIT(1))   u_d1   (.clk(clk), .rst_n(rst_n), .bus(i1));
    gf2_mul_raw_163 #(.DIGIT(7))   u_d7   (.clk(clk), .rst_n(rst_n), .bus(i7));
    gf2_mul_raw_163 #(.DIGIT(163)) u_d163 (.clk(clk), .rst_n(rst_n), .bus(i163));
    initial clk = 0;
    always #5 clk = ~clk;
    typedef struct {
        logic [162:0] a;
        logic [162:0] b;
        logic [325:0] p;
    } vec_t;
    vec_t v[12];
    task automatic chk(input string name, input logic [325:0] act, input logic [325:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [325:0] clmul(input logic [162:0] x, input logic [162:0] y);
        logic [325:0] r = '0;
        for (int i = 0; i < 163; i++)
            if (y[i]) r = r ^ ({163'b0, x} << i);
        return r;
    endfunction
    task automatic txn(input logic [162:0] ta, input logic [162:0] tb_v, input bit hold, input int stall,
                       output logic [325:0] p, output int lat);
        bit ir_bad, st_bad;
        logic [325:0] p0;
        @(negedge clk);
        m.a = ta; m.b = tb_v; m.in_valid = 1; m.out_ready = 0;
        @(posedge clk); #1;
        lat = 0; ir_bad = 0;
        while (!m.out_valid && lat < 400) begin
            if (m.in_ready || !m.busy) ir_bad = 1;
            if (hold) begin m.a = ~m.a; m.b = m.b + 163'd1; end
            else m.in_valid = 0;
            @(posedge clk); #1;
            lat++;
        end
        chk("run_in_ready_busy", {325'b0, ir_bad}, '0);
        chk("done_busy", {325'b0, m.busy}, 326'd1);
        p0 = m.product; st_bad = 0;
        repeat (stall) begin
            if (hold) m.in_valid = ~m.in_valid;
            m.a = ~m.a;
            @(posedge clk); #1;
            if (!m.out_valid || m.in_ready || m.product !== p0) st_bad = 1;
        end
        chk("done_stable", {325'b0, st_bad}, '0);
        p = p0;
        m.in_valid = 0; m.out_ready = 1;
        @(posedge clk); #1;
        chk("release_ready_valid", {324'b0, m.in_ready, m.out_valid}, 326'b10);
        chk("product_kept", m.product, p0);
        m.out_ready = 0;
    endtask
    task automatic trio(input logic [162:0] ta, input logic [162:0] tb_v, input logic [325:0] exp);
        int l1 = 0, l7 = 0, l163 = 0;
        @(negedge clk);
        i1.a = ta; i1.b = tb_v; i1.in_valid = 1;
        i7.a = ta; i7.b = tb_v; i7.in_valid = 1;
        i163.a = ta; i163.b = tb_v; i163.in_valid = 1;
        @(posedge clk); #1;
        i1.in_valid = 0; i7.in_valid = 0; i163.in_valid = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (i1.out_valid && l1 == 0) l1 = n;
            if (i7.out_valid && l7 == 0) l7 = n;
            if (i163.out_valid && l163 == 0) l163 = n;
        end
        chk("d1_lat", 326'(l1), 326'd163);
        chk("d7_lat", 326'(l7), 326'd24);
        chk("d163_lat", 326'(l163), 326'd1);
        chk("d1_prod", i1.product, exp);
        chk("d7_prod", i7.product, exp);
        chk("d163_prod", i163.product, exp);
    endtask
    initial begin
        logic [162:0] ones, top, ra, rb;
        logic [325:0] evens, pr;
        logic [191:0] r;
        int lat;
        ones = '1;
        top = 163'd1 << 162;
        evens = '0;
        for (int i = 0; i < 163; i++) evens[2*i] = 1'b1;
        v[0]  = '{163'd1, 163'd1, 326'd1};
        v[1]  = '{163'd3, 163'd3, 326'd5};
        v[2]  = '{163'd7, 163'd5, 326'h1B};
        v[3]  = '{top, top, 326'd1 << 324};
        v[4]  = '{ones, 163'd1, {163'b0, ones}};
        v[5]  = '{163'd0, ones, 326'd0};
        v[6]  = '{ones, 163'd0, 326'd0};
        v[7]  = '{163'd1, 163'd1 << 100, 326'd1 << 100};
        v[8]  = '{163'hFF, 163'hFF, 326'h5555};
        v[9]  = '{ones, ones, evens};
        v[10] = '{163'd3, ones, (326'd1 << 163) | 326'd1};
        v[11] = '{163'd5, top | (163'd1 << 7), (326'd5 << 162) | (326'd5 << 7)};
        m.in_valid = 0; m.out_ready = 0; m.a = '0; m.b = '0;
        i1.in_valid = 0; i1.out_ready = 1; i1.a = '0; i1.b = '0;
        i7.in_valid = 0; i7.out_ready = 1; i7.a = '0; i7.b = '0;
        i163.in_valid = 0; i163.out_ready = 1; i163.a = '0; i163.b = '0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {323'b0, m.in_ready, m.out_valid, m.busy}, 326'b100);
        chk("reset_product", m.product, '0);
        @(negedge clk) rst_n = 1;
        for (int k = 0; k < 12; k++) begin
            txn(v[k].a, v[k].b, 0, k % 3, pr, lat);
            chk($sformatf("vec%0d_prod", k), pr, v[k].p);
            chk($sformatf("vec%0d_lat", k), 326'(lat), 326'd21);
        end
        txn(163'd7, 163'd5, 1, 10, pr, lat);
        chk("hold_prod", pr, 326'h1B);
        chk("hold_lat", 326'(lat), 326'd21);
        @(negedge clk);
        m.a = 163'd3; m.b = 163'd3; m.in_valid = 1;
        @(posedge clk); #1;
        m.in_valid = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_run_busy", {325'b0, m.busy}, 326'd1);
        rst_n = 0;
        #1;
        chk("rst_run_flags", {323'b0, m.in_ready, m.out_valid, m.busy}, 326'b100);
        chk("rst_run_product", m.product, '0);
        @(negedge clk) rst_n = 1;
        txn(163'd3, 163'd3, 0, 0, pr, lat);
        chk("after_rst_prod", pr, 326'd5);
        chk("after_rst_lat", 326'(lat), 326'd21);
        @(negedge clk);
        m.a = 163'd7; m.b = 163'd5; m.in_valid = 1;
        @(posedge clk); #1;
        m.in_valid = 0;
        repeat (21) @(posedge clk);
        #1;
        chk("pre_rst_done", {324'b0, m.out_valid, m.busy}, 326'b11);
        rst_n = 0;
        #1;
        chk("rst_done_flags", {323'b0, m.in_ready, m.out_valid, m.busy}, 326'b100);
        chk("rst_done_product", m.product, '0);
        @(negedge clk) rst_n = 1;
        trio(ones, 163'd1, {163'b0, ones});
        trio(163'd3, top | 163'd1, (326'd3 << 162) | 326'd3);
        for (int k = 0; k < 200; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ra = r[162:0];
            r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rb = r[162:0];
            txn(ra, rb, k[0], int'($urandom_range(0, 3)), pr, lat);
            chk("rand_prod", pr, clmul(ra, rb));
            chk("rand_lat", 326'(lat), 326'd21);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gf2_mul_raw_163.md
Name: gf2_mul_raw_163

Overview:
Digit-serial carry-less polynomial multiplier over GF(2)[x] for 163-bit operands. Produces the unreduced 326-bit raw product that feeds the GF(2^163) reduction stage, P(x) = x^163 + x^7 + x^6 + x^3 + 1, directly downstream.
Operand A is processed in full each cycle; operand B is consumed one DIGIT-bit slice per cycle, MSB-first.
Valid/ready handshake on both the input and output sides.

Parameters:
DIGIT, 8, bits of B processed per cycle; legal range 1..163; elaboration error outside this range.
NDIG, derived = ceil(163/DIGIT), number of RUN cycles (21 at the default DIGIT).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  163  operand A, bit i = coeff of x^i
b  input  163  operand B, bit i = coeff of x^i
out_valid  output  1  product valid
out_ready  input  1  downstream (reducer) accepts product
product  output  326  raw carry-less product A*B, bit i = coeff of x^i
busy  output  1  high in RUN or DONE

Behaviour:
- Reset state (async assert, sync deassert at clk): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal A/B/count regs=0.
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready, latch a and b; B is zero-padded at the top to NDIG*DIGIT bits. Clear accumulator, set count=NDIG-1, go to RUN.
  - RUN: in_ready=0. Each cycle:
    - acc = (acc << DIGIT) XOR (a_reg * digit), where digit = B[count*DIGIT +: DIGIT] and * is carry-less (XOR of a_reg<<j for each set bit j of digit).
    - count decrements.
    - After the count=0 cycle, write acc to product and go to DONE.
  - DONE: out_valid=1, product stable. On out_ready go to IDLE and drop out_valid; product keeps its value until the next write.
- Latency: out_valid rises exactly NDIG clock edges after the accepting edge (21 at DIGIT=8). Throughput is one product per NDIG+2 cycles minimum. In the out_ready handshake cycle in_ready=0, so there is one idle bubble before the next accept.
- Input changes while not in IDLE are ignored. in_valid held high through RUN does not cause a second accept.
- Width rules: acc is 326 bits and the shift truncates at bit 325 (no overflow is possible). Max degree is 324, so product[325] is always 0. No modular reduction in this block.
- out_valid held with out_ready=0: product and out_valid hold indefinitely.
- Reset mid-RUN or mid-DONE: immediate return to reset state; the partial result is discarded and out_valid drops asynchronously.
- Operands of zero are legal; product=0 with normal latency.
- busy = (state != IDLE); in_ready = (state == IDLE).

Test Plan:
- a=1, b=1, out_ready=1 → out_valid rises 21 edges after accept; product=1; in_ready=0 throughout RUN/DONE.
- a=3, b=3 → product=5 (x^2+1, no carry). a=7, b=5 → product=0x1B.
- a=1<<162, b=1<<162 → product has only bit 324 set, bit 325=0. Then feed the reduction stage and compare against a software reference modulo P.
- a=all-ones (163 bits), b=1 → product[162:0]=all-ones, upper bits 0. Repeat at DIGIT=1 (latency 163), DIGIT=7 (NDIG=24, padding path) and DIGIT=163 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and product stable. in_valid toggling during RUN/DONE is ignored. Release out_ready → IDLE next edge; in_ready=1.
- Reset: assert rst_n=0 at RUN count=10 → all outputs at reset values immediately. After release, a new a=3, b=3 gives product=5 with full latency.
- Random regression: 10k random a/b pairs with random out_ready stalls → product equals the software carry-less multiply.
